instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 157 +++++++++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the program ROM address, assembles AVR two-word instructions, presents them over valid/ready.
// Optional BREAK halt enabled by defining IFETCH_HALT_EN; default build passes BREAK through as an ordinary instruction.
module instr_fetch #(
   parameter int          DATA_WIDTH   = 16,
   parameter int          ADDR_WIDTH   = 8,
   parameter int unsigned RESET_VECTOR = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] o_rom_addr,
   input  logic [DATA_WIDTH-1:0] i_rom_data,
   input  logic                  i_redirect_valid,
   input  logic [ADDR_WIDTH-1:0] i_redirect_target,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [DATA_WIDTH-1:0] o_instr,
   output logic [DATA_WIDTH-1:0] o_instr_ext,
   output logic [ADDR_WIDTH-1:0] o_instr_pc,
   output logic                  o_two_word,
   output logic                  o_halted
);

`ifdef IFETCH_HALT_EN
   typedef enum logic [1:0] {S_FETCH, S_FETCH2, S_HALT} state_t;
`else
   typedef enum logic [1:0] {S_FETCH, S_FETCH2} state_t;
`endif

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_rom_addr, w_rom_addr_nxt;
   logic [DATA_WIDTH-1:0] r_partial, w_partial_nxt;
   logic                  r_out_valid, w_out_valid_nxt;
   logic [DATA_WIDTH-1:0] r_instr, w_instr_nxt;
   logic [DATA_WIDTH-1:0] r_instr_ext, w_instr_ext_nxt;
   logic [ADDR_WIDTH-1:0] r_instr_pc, w_instr_pc_nxt;
   logic                  r_two_word, w_two_word_nxt;
   logic                  w_slot_free;
   logic                  w_is_two;
`ifdef IFETCH_HALT_EN
   logic                  r_halted, w_halted_nxt;
   logic                  w_is_break;
`endif

   // LDS/STS and JMP/CALL carry a second word (address/constant)
   assign w_is_two = ((i_rom_data[15:10] == 6'b100100) && (i_rom_data[3:0] == 4'b0000)) ||
                     ((i_rom_data[15:9]  == 7'b1001010) && (i_rom_data[3:2] == 2'b11));
   assign w_slot_free = !r_out_valid || i_out_ready;
`ifdef IFETCH_HALT_EN
   assign w_is_break = (i_rom_data == DATA_WIDTH'(16'h9598));
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_rom_addr_nxt  = r_rom_addr;
      w_partial_nxt   = r_partial;
      w_out_valid_nxt = r_out_valid;
      w_instr_nxt     = r_instr;
      w_instr_ext_nxt = r_instr_ext;
      w_instr_pc_nxt  = r_instr_pc;
      w_two_word_nxt  = r_two_word;
`ifdef IFETCH_HALT_EN
      w_halted_nxt    = r_halted;
`endif
      if (i_redirect_valid) begin
         w_state_nxt     = S_FETCH;
         w_rom_addr_nxt  = i_redirect_target;
         w_partial_nxt   = '0;
         w_out_valid_nxt = 1'b0;
`ifdef IFETCH_HALT_EN
         w_halted_nxt    = 1'b0;
`endif
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_slot_free) begin
`ifdef IFETCH_HALT_EN
                  if (w_is_break) begin
                     // address stays on the BREAK word so a debugger sees where fetch stopped
                     w_out_valid_nxt = 1'b0;
                     w_halted_nxt    = 1'b1;
                     w_state_nxt     = S_HALT;
                  end else
`endif
                  if (w_is_two) begin
                     w_partial_nxt   = i_rom_data;
                     w_rom_addr_nxt  = r_rom_addr + ADDR_WIDTH'(1);
                     w_out_valid_nxt = 1'b0;
                     w_state_nxt     = S_FETCH2;
                  end else begin
                     w_instr_nxt     = i_rom_data;
                     w_instr_ext_nxt = '0;
                     w_two_word_nxt  = 1'b0;
                     w_instr_pc_nxt  = r_rom_addr;
                     w_out_valid_nxt = 1'b1;
                     w_rom_addr_nxt  = r_rom_addr + ADDR_WIDTH'(1);
                  end
               end
            end
            S_FETCH2: begin
               w_instr_nxt     = r_partial;
               w_instr_ext_nxt = i_rom_data;
               w_two_word_nxt  = 1'b1;
               w_instr_pc_nxt  = r_rom_addr - ADDR_WIDTH'(1);
               w_out_valid_nxt = 1'b1;
               w_rom_addr_nxt  = r_rom_addr + ADDR_WIDTH'(1);
               w_state_nxt     = S_FETCH;
            end
            default: begin
`ifndef IFETCH_HALT_EN
               w_state_nxt = S_FETCH;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FETCH;
         r_rom_addr  <= ADDR_WIDTH'(RESET_VECTOR);
         r_partial   <= '0;
         r_out_valid <= 1'b0;
         r_instr     <= '0;
         r_instr_ext <= '0;
         r_instr_pc  <= '0;
         r_two_word  <= 1'b0;
`ifdef IFETCH_HALT_EN
         r_halted    <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_rom_addr  <= w_rom_addr_nxt;
         r_partial   <= w_partial_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_instr     <= w_instr_nxt;
         r_instr_ext <= w_instr_ext_nxt;
         r_instr_pc  <= w_instr_pc_nxt;
         r_two_word  <= w_two_word_nxt;
`ifdef IFETCH_HALT_EN
         r_halted    <= w_halted_nxt;
`endif
      end
   end

   assign o_rom_addr  = r_rom_addr;
   assign o_out_valid = r_out_valid;
   assign o_instr     = r_instr;
   assign o_instr_ext = r_instr_ext;
   assign o_instr_pc  = r_instr_pc;
   assign o_two_word  = r_two_word;
`ifdef IFETCH_HALT_EN
   assign o_halted    = r_halted;
`else
   assign o_halted    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed walk through the fetch scenarios, then random ready/redirect traffic
// against an instruction-stream reference model. Honours IFETCH_HALT_EN for the BREAK scenario.
module tb_instr_fetch;
   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] o_rom_addr;
   logic [DW-1:0] i_rom_data;
   logic          i_redirect_valid = 1'b0;
   logic [AW-1:0] i_redirect_target = '0;
   logic          o_out_valid;
   logic          i_out_ready = 1'b1;
   logic [DW-1:0] o_instr;
   logic [DW-1:0] o_instr_ext;
   logic [AW-1:0] o_instr_pc;
   logic          o_two_word;
   logic          o_halted;

   logic [DW-1:0] rom [256];
   int n_checks = 0;
   int n_errors = 0;

   instr_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_VECTOR(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
      .i_redirect_valid(i_redirect_valid), .i_redirect_target(i_redirect_target),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
      .o_instr(o_instr), .o_instr_ext(o_instr_ext), .o_instr_pc(o_instr_pc),
      .o_two_word(o_two_word), .o_halted(o_halted)
   );

   always #5 clk = ~clk;

   // ROM registers the addressed word on the falling edge
   always @(negedge clk) i_rom_data <= rom[o_rom_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic is_two(input logic [15:0] w);
      return ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000)) ||
             ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11));
   endfunction

   task automatic check_slot(input string tag, input logic [15:0] ins, input logic [15:0] ext,
                             input logic [7:0] pc, input logic tw);
      check({tag, ".vld"}, o_out_valid, 1);
      check({tag, ".instr"}, o_instr, ins);
      check({tag, ".ext"}, o_instr_ext, ext);
      check({tag, ".pc"}, o_instr_pc, pc);
      check({tag, ".tw"}, o_two_word, tw);
   endtask

   task automatic redirect_to(input logic [7:0] tgt);
      i_redirect_valid = 1'b1;
      i_redirect_target = tgt;
      tick;
      i_redirect_valid = 1'b0;
   endtask

   initial begin
      logic [7:0]  m_pc;
      logic [15:0] w;
      int          idle;
      int          n_xfer;

      for (int i = 0; i < 256; i++) rom[i] = 16'hE000 | 16'(i);
      rom[0] = 16'hE005; rom[1] = 16'hE01F; rom[2] = 16'h930F;
      rom[3] = 16'h9100; rom[4] = 16'h0123;
      rom[7] = 16'h940C; rom[8] = 16'h0040;
      rom[255] = 16'h940E;

      repeat (3) tick;
      check("rst.vld", o_out_valid, 0);
      check("rst.instr", o_instr, 0);
      check("rst.ext", o_instr_ext, 0);
      check("rst.pc", o_instr_pc, 0);
      check("rst.tw", o_two_word, 0);
      check("rst.halted", o_halted, 0);
      check("rst.addr", o_rom_addr, 0);

      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rel.vld", o_out_valid, 0);
      tick; check_slot("seq0", 16'hE005, 0, 8'h00, 0); check("seq0.addr", o_rom_addr, 1);
      tick; check_slot("seq1", 16'hE01F, 0, 8'h01, 0);
      tick; check_slot("seq2", 16'h930F, 0, 8'h02, 0);
      tick; check("lds.gap", o_out_valid, 0); check("lds.addr", o_rom_addr, 4);
      tick; check_slot("lds", 16'h9100, 16'h0123, 8'h03, 1);
      tick; check_slot("after_lds", 16'hE005, 0, 8'h05, 0);

      i_out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick;
         check_slot("stall", 16'hE005, 0, 8'h05, 0);
         check("stall.addr", o_rom_addr, 6);
      end
      i_out_ready = 1'b1;
      tick; check_slot("unstall", 16'hE006, 0, 8'h06, 0); check("unstall.addr", o_rom_addr, 7);

      tick; check("jmp.f2vld", o_out_valid, 0); check("jmp.f2addr", o_rom_addr, 8);
      redirect_to(8'h0C);
      check("redir.vld", o_out_valid, 0); check("redir.addr", o_rom_addr, 8'h0C);
      tick; check_slot("redir.tgt", 16'hE00C, 0, 8'h0C, 0);

      rom[0] = 16'h1234;
      redirect_to(8'hFF);
      check("wrap.addr", o_rom_addr, 8'hFF);
      tick; check("wrap.gap", o_out_valid, 0); check("wrap.addr0", o_rom_addr, 0);
      tick; check_slot("wrap", 16'h940E, 16'h1234, 8'hFF, 1);
      tick; check_slot("wrap.next", 16'hE01F, 0, 8'h01, 0);

      redirect_to(8'h07);
      tick; check("mid.f2vld", o_out_valid, 0);
      #2 rst_n = 1'b0;
      #1 check("arst.vld", o_out_valid, 0); check("arst.addr", o_rom_addr, 0);
      check("arst.instr", o_instr, 0); check("arst.tw", o_two_word, 0);
      rom[2] = 16'h9598;
      @(negedge clk);
      rst_n = 1'b1;
      tick; check_slot("post0", 16'h1234, 0, 8'h00, 0);
      tick; check_slot("post1", 16'hE01F, 0, 8'h01, 0);
      tick;
`ifdef IFETCH_HALT_EN
      check("brk.vld", o_out_valid, 0); check("brk.halted", o_halted, 1); check("brk.addr", o_rom_addr, 2);
      repeat (3) tick;
      check("halt.vld", o_out_valid, 0); check("halt.halted", o_halted, 1); check("halt.addr", o_rom_addr, 2);
      redirect_to(8'h00);
      check("unhalt.halted", o_halted, 0); check("unhalt.addr", o_rom_addr, 0);
      tick; check_slot("resume", 16'h1234, 0, 8'h00, 0);
`else
      check_slot("brk", 16'h9598, 0, 8'h02, 0);
      check("brk.halted", o_halted, 0);
`endif

      // random program and traffic, checked against the expected instruction stream
      i_redirect_valid = 1'b1;
      i_redirect_target = 8'($urandom);
      m_pc = i_redirect_target;
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         case ($urandom_range(0, 7))
            0: w = (w & 16'h03F0) | 16'h9000;
            1: w = (w & 16'h01F3) | 16'h940C;
            default: ;
         endcase
`ifdef IFETCH_HALT_EN
         if (w == 16'h9598) w = 16'h0000;
`endif
         rom[i] = w;
      end
      tick;
      i_redirect_valid = 1'b0;
      idle = 0;
      n_xfer = 0;
      for (int c = 0; c < 3000; c++) begin
         logic       xfer;
         logic       redir;
         logic [7:0] tgt;
         i_out_ready = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 19) == 0);
         tgt = 8'($urandom);
         i_redirect_valid = redir;
         i_redirect_target = tgt;
         xfer = o_out_valid && i_out_ready;
         tick;
         if (xfer) begin
            n_xfer++;
            m_pc = is_two(rom[m_pc]) ? 8'(m_pc + 8'd2) : 8'(m_pc + 8'd1);
         end
         if (redir) begin
            m_pc = tgt;
            check("rnd.redir_vld", o_out_valid, 0);
         end
         if (xfer || redir) idle = 0;
         else idle++;
         if (o_out_valid) begin
            w = rom[m_pc];
            check("rnd.instr", o_instr, w);
            check("rnd.pc", o_instr_pc, m_pc);
            check("rnd.tw", o_two_word, is_two(w));
            check("rnd.ext", o_instr_ext, is_two(w) ? rom[8'(m_pc + 8'd1)] : 16'h0000);
         end
         if (idle > 40) begin
            check("rnd.progress", 0, 1);
            idle = 0;
         end
      end
      i_redirect_valid = 1'b0;
      check("rnd.some_xfers", (n_xfer > 500), 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
